// File: rtl/crc_check_sched.sv
// Round-robin front end that time-shares one CRC-4 checker among N_REQ clients.
// It handles one job at a time: it grants one client, runs the checker, reports the result, then clears the checker for a cycle.
module crc_check_sched #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [3:0]         rsp_data,
  output logic               rsp_ok,
  output logic               rsp_timeout,
  output logic               busy,
  output logic [CNT_W-1:0]   err_count,
  output logic               chk_start,
  output logic [7:0]         chk_data,
  input  logic               chk_ready,
  input  logic               chk_valid,
  input  logic [3:0]         chk_nibble
);

  localparam int TM_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLEAR} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [TM_W-1:0]    timer_q, timer_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [3:0]         rsp_data_q, rsp_data_d;
  logic               rsp_ok_q, rsp_ok_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               chk_start_q, chk_start_d;
  logic [7:0]         chk_data_q, chk_data_d;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [7:0]         win_data;
  logic               tmo_hit;

  assign tmo_hit = (timer_q == TM_W'(TIMEOUT - 1));

  // Scan starts one past the last winner so every client gets a turn.
  always_comb begin : arb
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = ptr_q;
    win_data  = 8'h00;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
        win_data  = req_data[8*idx +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_RUN;
      S_RUN:   if (chk_ready || tmo_hit) state_d = S_CLEAR;
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d         = ptr_q;
    timer_d       = timer_q;
    gnt_d         = '0;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_ok_d      = rsp_ok_q;
    rsp_timeout_d = rsp_timeout_q;
    chk_start_d   = chk_start_q;
    chk_data_d    = chk_data_q;
    err_count_d   = err_count_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d       = N_REQ'(1) << win_id;
          chk_data_d  = win_data;
          rsp_id_d    = win_id;
          ptr_d       = win_id;
          chk_start_d = 1'b1;
          timer_d     = '0;
        end
      end
      S_RUN: begin
        timer_d = timer_q + 1'b1;
        // A ready checker beats a timeout landing on the same cycle.
        if (chk_ready) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = chk_nibble;
          rsp_ok_d      = chk_valid;
          rsp_timeout_d = 1'b0;
          chk_start_d   = 1'b0;
        end else if (tmo_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = 4'h0;
          rsp_ok_d      = 1'b0;
          rsp_timeout_d = 1'b1;
          chk_start_d   = 1'b0;
        end
      end
      default: chk_start_d = 1'b0;
    endcase
    if (rsp_valid_d && !rsp_ok_d && (err_count_q != {CNT_W{1'b1}}))
      err_count_d = err_count_q + 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= ID_W'(N_REQ - 1);
      timer_q       <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= 4'h0;
      rsp_ok_q      <= 1'b0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      err_count_q   <= '0;
      chk_start_q   <= 1'b0;
      chk_data_q    <= 8'h00;
    end else begin
      ptr_q         <= ptr_d;
      timer_q       <= timer_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_ok_q      <= rsp_ok_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      err_count_q   <= err_count_d;
      chk_start_q   <= chk_start_d;
      chk_data_q    <= chk_data_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_ok      = rsp_ok_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign err_count   = err_count_q;
  assign chk_start   = chk_start_q;
  assign chk_data    = chk_data_q;

endmodule

// File: tb/tb_crc_check_sched.sv
// Directed bench for crc_check_sched with a behavioural CRC-4 checker that becomes ready 5 start-sampled edges after start.
module tb_crc_check_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_data;
  logic        rsp_ok;
  logic        rsp_timeout;
  logic        busy;
  logic [3:0]  err_count;
  logic        chk_start;
  logic [7:0]  chk_data;
  logic        chk_ready;
  logic        chk_valid;
  logic [3:0]  chk_nibble;

  int total = 0;
  int bad   = 0;

  crc_check_sched #(.N_REQ(4), .TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ok(rsp_ok),
    .rsp_timeout(rsp_timeout), .busy(busy), .err_count(err_count),
    .chk_start(chk_start), .chk_data(chk_data), .chk_ready(chk_ready),
    .chk_valid(chk_valid), .chk_nibble(chk_nibble)
  );

  always #5 clk = ~clk;

  // Checker model: counts edges with start high, clears while start is low.
  logic [2:0] mcnt = 3'd0;
  logic       rdy_en;
  always @(posedge clk) begin
    if (!chk_start)        mcnt <= 3'd0;
    else if (mcnt != 3'd5) mcnt <= mcnt + 3'd1;
  end

  function automatic logic [3:0] crc_rem(input logic [7:0] cw);
    logic [7:0] r;
    r = cw;
    for (int b = 7; b >= 4; b--)
      if (r[b]) r = r ^ (8'h13 << (b - 4));
    return r[3:0];
  endfunction

  assign chk_ready  = rdy_en && (mcnt == 3'd5);
  assign chk_valid  = (crc_rem(chk_data) == 4'h0);
  assign chk_nibble = chk_data[7:4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_job(input int id, input logic [7:0] cw, input logic [3:0] nib_e,
                        input logic ok_e, input logic to_e, input int lat_e, input int err_e);
    int   n;
    logic seen;
    logic held;
    req_data[8*id +: 8] = cw;
    req = 4'b0001 << id;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (gnt != 4'b0000) seen = 1'b1;
    end
    check("gnt_seen", seen, 1);
    if (!seen) begin
      req = 4'b0000;
      return;
    end
    check("gnt", gnt, 4'b0001 << id);
    check("chk_start_on", chk_start, 1);
    check("chk_data", chk_data, cw);
    check("busy_on", busy, 1);
    req = 4'b0000;
    seen = 1'b0;
    held = 1'b1;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) seen = 1'b1;
      else if (chk_data != cw || !chk_start || !busy) held = 1'b0;
    end
    check("rsp_seen", seen, 1);
    if (!seen) return;
    check("run_hold", held, 1);
    check("latency", n, lat_e);
    check("rsp_id", rsp_id, id);
    check("rsp_data", rsp_data, nib_e);
    check("rsp_ok", rsp_ok, ok_e);
    check("rsp_timeout", rsp_timeout, to_e);
    check("chk_start_off", chk_start, 0);
    @(posedge clk); #1;
    check("rsp_pulse", rsp_valid, 0);
    check("busy_off", busy, 0);
    check("err_count", err_count, err_e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, last, g, r, n, rsp_cnt;
    logic seen;
    rst_n    = 1'b0;
    req      = 4'b0000;
    req_data = 32'h0;
    rdy_en   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_chk_start", chk_start, 0);
    check("rst_chk_data", chk_data, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;

    // Good codeword, corrupted codeword, then a checker that never answers.
    do_job(0, 8'h13, 4'h1, 1'b1, 1'b0, 6, 0);
    do_job(2, 8'h12, 4'h1, 1'b0, 1'b0, 6, 1);
    rdy_en = 1'b0;
    do_job(1, 8'h13, 4'h0, 1'b0, 1'b1, 15, 2);
    rdy_en = 1'b1;

    // Reset two cycles into a job owned by requester 0.
    req_data[7:0] = 8'h13;
    req = 4'b0001;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (gnt != 4'b0000) seen = 1'b1;
    end
    check("mid_gnt_seen", seen, 1);
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_chk_start", chk_start, 0);
    check("mid_busy", busy, 0);
    check("mid_err_count", err_count, 0);
    rsp_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst_n = 1'b1;
      if (rsp_valid) rsp_cnt++;
    end
    check("mid_no_rsp", rsp_cnt, 0);

    // All four requesting; a reset pointer must start the rotation at 0.
    req_data = {8'h13, 8'hAD, 8'h13, 8'hAD};
    req = 4'b1111;
    cyc = 0; last = 0; g = 0; r = 0;
    while (r < 5 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (gnt != 4'b0000) begin
        check("rr_gnt", gnt, 4'b0001 << (g % 4));
        if (g > 0) check("rr_gap", cyc - last, 8);
        last = cyc;
        g++;
        if (g == 5) req = 4'b0000;
      end
      if (rsp_valid) begin
        check("rr_id", rsp_id, r % 4);
        check("rr_data", rsp_data, (r % 2) ? 4'h1 : 4'hA);
        check("rr_ok", rsp_ok, 1);
        r++;
      end
    end
    req = 4'b0000;
    check("rr_grants", g, 5);
    check("rr_rsps", r, 5);
    @(posedge clk); #1;
    check("rr_err_count", err_count, 0);

    // Seventeen failures into a 4-bit counter.
    for (int k = 1; k <= 17; k++)
      do_job(3, 8'h12, 4'h1, 1'b0, 1'b0, 6, (k > 15) ? 15 : k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
